bypass_scoreboard: RTL and testbench
====================================

# bypass_scoreboard

Parametrised operand-bypass and hazard unit for the in-order pipeline, sitting beside decode. It resolves each decode source operand against NSTG in-flight producer stages plus writeback. It also keeps a per-register busy scoreboard so that producers not visible in any forwarding stage still cause stalls. It drives the decode stall and operand-mux selects, and keeps a saturating stall-cycle counter for performance monitoring.

## Interface
Parameters:
- XLEN, 32, data width
- NREG, 32, architectural registers; register 0 is hard-wired zero
- AW, 5, register address width; must satisfy 2**AW >= NREG
- NSTG, 8, forwarding stages; index 0 is youngest (EXE), NSTG-1 oldest
- NRD, 2, decode read ports
- CW, 32, stall counter width

Ports (reset is asynchronous and active-high):
- clk_i  in  1  clock
- rst_i  in  1  async active-high reset
- dec_valid_i  in  1  decode holds a valid instruction
- dec_rd_addr_i  in  NRD*AW  source addresses; port p at [p*AW +: AW]
- dec_rd_use_i  in  NRD  port p actually reads its source
- dec_wr_en_i  in  1  instruction writes a register
- dec_wr_addr_i  in  AW  destination address
- stg_valid_i  in  NSTG  stage s holds a register-writing instruction
- stg_addr_i  in  NSTG*AW  destination address of stage s
- stg_ready_i  in  NSTG  stage s result is final (ALU done, cache hit, multiplier last stage)
- stg_data_i  in  NSTG*XLEN  result of stage s
- wb_en_i, wb_addr_i, wb_data_i  in  1/AW/XLEN  register-file write this cycle
- flush_i  in  1  pipeline flush
- stall_o  out  1  hold decode
- byp_en_o  out  NRD  use byp_data_o instead of the register-file value
- byp_data_o  out  NRD*XLEN  forwarded operand per port
- stall_cnt_o  out  CW  saturating count of stalled cycles

## Operation
- **Operand resolution.** Applies only to a port with dec_rd_use_i=1 and addr≠0. Scan stages 0..NSTG-1 and take the first s with stg_valid_i[s] and a matching address.
  - If stg_ready_i[s]=1: byp_en=1, data=stg_data_i[s].
  - Else: the port hazards (byp_en=0).
  - If no stage matches and wb_en_i & wb_addr_i==addr: bypass wb_data_i.
  - If no stage matches, no wb match and busy[addr]=1: the port hazards.
  - Otherwise: byp_en=0, data=0.
- **RAW stall.** stall_o = dec_valid_i & (any port hazards | WAW hazard).
- **WAW hazard.** dec_wr_en_i, dec_wr_addr_i≠0, busy[dec_wr_addr_i]=1 and not cleared by wb this cycle. This keeps writeback in order across variable-latency units.
- **Scoreboard update** (clocked):
  - Issue = dec_valid_i & dec_wr_en_i & dec_wr_addr_i≠0 & !stall_o. Issue sets busy[dec_wr_addr_i].
  - wb_en_i clears busy[wb_addr_i].
  - When issue and wb hit the same address, set wins.
  - busy[0] is always 0.
- **Flush.** flush_i clears all busy bits next edge, overriding set. Combinational outputs are unaffected in the flush cycle.
- **Stall counter.** +1 per cycle with stall_o=1; saturates at all-ones and holds there.
- **Reset.** busy=0 and stall_cnt_o=0. While rst_i=1, stall_o=0, byp_en_o=0 and byp_data_o=0 (forced combinationally).

## Timing
- byp_en_o, byp_data_o and stall_o are combinational from inputs and the busy register, with zero latency.
- busy and stall_cnt_o update on the rising clk_i edge. A set by issue in cycle n is visible in cycle n+1.
- A wb clear is visible in the same cycle through the wb bypass path, and in the register from n+1.
- Priority is youngest stage, then older stages, then wb, then busy. A younger non-ready match stalls even when an older ready match exists.
- Reset assertion clears state immediately, asynchronously. Reset deassertion mid-stream restarts from an empty scoreboard.

## Test plan
1. Stage 0 valid, addr=5, ready, data=0xAAAA0001; dec reads r5 on port 0 -> byp_en_o=01, port0 data=0xAAAA0001, stall_o=0.
2. Stage 0 addr=7 not ready (load miss), stage 3 addr=7 ready; port 1 reads r7 -> stall_o=1, byp_en_o[1]=0; stall_cnt_o increments by 1 per cycle.
3. Issue write r9 with no stage showing r9 (multiplier). Next cycle read r9 -> stall_o=1. Then wb_en_i, wb_addr=9, data=0x1234 -> same cycle bypass 0x1234, stall_o=0; busy[9]=0 afterwards.
4. busy[4]=1; dec writes r4 -> WAW stall. Same cycle wb to r4 -> no stall, and busy[4] remains set by the new issue.
5. Reads and writes of r0 with matching stages -> never bypass, never stall, busy[0] stays 0.
6. Set busy on r3, r6, then assert flush_i -> both clear next cycle. Force stall_cnt_o to all-ones (CW=4 build) and stall further -> holds 0xF. Assert rst_i asynchronously mid-stall -> outputs 0 immediately.

Source files
------------

// File: rtl/bypass_scoreboard.sv
// Operand bypass, RAW/WAW hazard detection and per-register busy scoreboard beside decode.
// Latency: outputs combinational from inputs and busy; state on clk_i. Backpressure: stall_o holds decode.
module bypass_scoreboard #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int NSTG = 8,
  parameter int NRD  = 2,
  parameter int CW   = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 dec_valid_i,
  input  logic [NRD*AW-1:0]    dec_rd_addr_i,
  input  logic [NRD-1:0]       dec_rd_use_i,
  input  logic                 dec_wr_en_i,
  input  logic [AW-1:0]        dec_wr_addr_i,
  input  logic [NSTG-1:0]      stg_valid_i,
  input  logic [NSTG*AW-1:0]   stg_addr_i,
  input  logic [NSTG-1:0]      stg_ready_i,
  input  logic [NSTG*XLEN-1:0] stg_data_i,
  input  logic                 wb_en_i,
  input  logic [AW-1:0]        wb_addr_i,
  input  logic [XLEN-1:0]      wb_data_i,
  input  logic                 flush_i,
  output logic                 stall_o,
  output logic [NRD-1:0]       byp_en_o,
  output logic [NRD*XLEN-1:0]  byp_data_o,
  output logic [CW-1:0]        stall_cnt_o
);

  localparam int NB = 1 << AW;

  logic [NB-1:0]  busy_q;
  logic [NB-1:0]  busy_d;
  logic [NRD-1:0] hazard;
  logic [AW-1:0]  ra;
  logic           hit;
  logic           wb_hit_wr;
  logic           waw;
  logic           issue;

  // Youngest matching stage wins outright, even if it is not ready and an older one is.
  always_comb begin
    hazard     = '0;
    byp_en_o   = '0;
    byp_data_o = '0;
    ra         = '0;
    hit        = 1'b0;
    for (int p = 0; p < NRD; p++) begin
      ra  = dec_rd_addr_i[p*AW +: AW];
      hit = 1'b0;
      if (!rst_i && dec_rd_use_i[p] && ra != '0) begin
        for (int s = 0; s < NSTG; s++) begin
          if (!hit && stg_valid_i[s] && stg_addr_i[s*AW +: AW] == ra) begin
            hit = 1'b1;
            if (stg_ready_i[s]) begin
              byp_en_o[p]                 = 1'b1;
              byp_data_o[p*XLEN +: XLEN]  = stg_data_i[s*XLEN +: XLEN];
            end else begin
              hazard[p] = 1'b1;
            end
          end
        end
        if (!hit) begin
          if (wb_en_i && wb_addr_i == ra) begin
            byp_en_o[p]                = 1'b1;
            byp_data_o[p*XLEN +: XLEN] = wb_data_i;
          end else if (busy_q[ra]) begin
            hazard[p] = 1'b1;
          end
        end
      end
    end
  end

  assign wb_hit_wr = wb_en_i && wb_addr_i == dec_wr_addr_i;
  assign waw       = dec_wr_en_i && dec_wr_addr_i != '0 && busy_q[dec_wr_addr_i] && !wb_hit_wr;
  assign stall_o   = !rst_i && dec_valid_i && (|hazard || waw);
  assign issue     = dec_valid_i && dec_wr_en_i && dec_wr_addr_i != '0 && !stall_o;

  // Set after clear so a same-address issue wins over writeback; flush overrides both.
  always_comb begin
    busy_d = busy_q;
    if (wb_en_i)
      busy_d[wb_addr_i] = 1'b0;
    if (issue && int'(dec_wr_addr_i) < NREG)
      busy_d[dec_wr_addr_i] = 1'b1;
    if (flush_i)
      busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q      <= '0;
      stall_cnt_o <= '0;
    end else begin
      busy_q <= busy_d;
      if (stall_o && stall_cnt_o != {CW{1'b1}})
        stall_cnt_o <= stall_cnt_o + CW'(1);
    end
  end

endmodule

// File: tb/tb_bypass_scoreboard.sv
// Bench for bypass_scoreboard (CW=4): directed literal cases, then randomized traffic
// checked every cycle against a register-level behavioural model.
module tb_bypass_scoreboard;

  logic         clk = 1'b0;
  logic         rst;
  logic         dec_valid;
  logic [9:0]   rd_addr;
  logic [1:0]   rd_use;
  logic         wr_en;
  logic [4:0]   wr_addr;
  logic [7:0]   stg_valid;
  logic [39:0]  stg_addr;
  logic [7:0]   stg_ready;
  logic [255:0] stg_data;
  logic         wb_en;
  logic [4:0]   wb_addr;
  logic [31:0]  wb_data;
  logic         flush;
  logic         stall;
  logic [1:0]   byp_en;
  logic [63:0]  byp_data;
  logic [3:0]   cnt;

  int checks = 0;
  int failures = 0;

  bypass_scoreboard #(.XLEN(32), .NREG(32), .AW(5), .NSTG(8), .NRD(2), .CW(4)) dut (
    .clk_i(clk), .rst_i(rst), .dec_valid_i(dec_valid), .dec_rd_addr_i(rd_addr),
    .dec_rd_use_i(rd_use), .dec_wr_en_i(wr_en), .dec_wr_addr_i(wr_addr),
    .stg_valid_i(stg_valid), .stg_addr_i(stg_addr), .stg_ready_i(stg_ready),
    .stg_data_i(stg_data), .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .flush_i(flush), .stall_o(stall), .byp_en_o(byp_en), .byp_data_o(byp_data),
    .stall_cnt_o(cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Behavioural model: busy set of registers and a saturating stall count.
  logic [31:0] mbusy = '0;
  logic [31:0] nbusy = '0;
  int          mcnt = 0;
  int          ncnt = 0;
  logic        e_st, e_iss;
  logic [1:0]  e_en;
  logic [63:0] e_dat;

  function automatic void model_eval(output logic st, output logic [1:0] en,
                                     output logic [63:0] dat, output logic iss);
    logic hz;
    int first;
    logic [4:0] a;
    hz = 1'b0; en = '0; dat = '0;
    for (int p = 0; p < 2; p++) begin
      a = rd_addr[p*5 +: 5];
      if (!rd_use[p] || a == 5'd0) continue;
      first = -1;
      for (int s = 0; s < 8; s++)
        if (stg_valid[s] && stg_addr[s*5 +: 5] == a) begin first = s; break; end
      if (first >= 0) begin
        if (stg_ready[first]) begin en[p] = 1'b1; dat[p*32 +: 32] = stg_data[first*32 +: 32]; end
        else hz = 1'b1;
      end else if (wb_en && wb_addr == a) begin
        en[p] = 1'b1; dat[p*32 +: 32] = wb_data;
      end else if (mbusy[a]) hz = 1'b1;
    end
    if (wr_en && wr_addr != 5'd0 && mbusy[wr_addr] && !(wb_en && wb_addr == wr_addr)) hz = 1'b1;
    st  = dec_valid && hz;
    iss = dec_valid && wr_en && wr_addr != 5'd0 && !st;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_stall", 64'(stall), 64'd0);
      chk("rst_byp_en", 64'(byp_en), 64'd0);
      chk("rst_byp_data", byp_data, 64'd0);
      chk("rst_cnt", 64'(cnt), 64'd0);
    end else begin
      model_eval(e_st, e_en, e_dat, e_iss);
      chk("model_stall", 64'(stall), 64'(e_st));
      chk("model_byp_en", 64'(byp_en), 64'(e_en));
      chk("model_byp_data", byp_data, e_dat);
      chk("model_cnt", 64'(cnt), 64'(mcnt));
      nbusy = mbusy;
      if (wb_en) nbusy[wb_addr] = 1'b0;
      if (e_iss) nbusy[wr_addr] = 1'b1;
      if (flush) nbusy = '0;
      nbusy[0] = 1'b0;
      ncnt = (e_st && mcnt < 15) ? mcnt + 1 : mcnt;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mbusy = '0; mcnt = 0;
    end else begin
      mbusy = nbusy; mcnt = ncnt;
    end
  end

  task automatic clr();
    dec_valid = 0; rd_addr = '0; rd_use = '0; wr_en = 0; wr_addr = '0;
    stg_valid = '0; stg_addr = '0; stg_ready = '0; stg_data = '0;
    wb_en = 0; wb_addr = '0; wb_data = '0; flush = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    dec_valid = 1'($urandom);
    rd_use    = 2'($urandom);
    rd_addr   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
    wr_en     = 1'($urandom);
    wr_addr   = 5'($urandom_range(0, 7));
    stg_valid = 8'($urandom & $urandom);
    stg_ready = 8'($urandom | $urandom);
    for (int s = 0; s < 8; s++) begin
      stg_addr[s*5 +: 5]   = 5'($urandom_range(0, 7));
      stg_data[s*32 +: 32] = $urandom;
    end
    wb_en   = 1'($urandom);
    wb_addr = 5'($urandom_range(0, 7));
    wb_data = $urandom;
    flush   = ($urandom_range(0, 31) == 0);
  endtask

  initial begin
    clr();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_cnt", 64'(cnt), 64'd0);
    step();
    rst = 1'b0;

    // Ready youngest stage forwards
    clr(); dec_valid = 1; rd_use = 2'b01; rd_addr[4:0] = 5'd5;
    stg_valid[0] = 1; stg_addr[4:0] = 5'd5; stg_ready[0] = 1; stg_data[31:0] = 32'hAAAA0001;
    @(negedge clk);
    chk("t1_en", 64'(byp_en), 64'b01);
    chk("t1_data", 64'(byp_data[31:0]), 64'hAAAA0001);
    chk("t1_stall", 64'(stall), 64'd0);
    step();

    // Younger non-ready match shadows an older ready one
    clr(); dec_valid = 1; rd_use = 2'b10; rd_addr[9:5] = 5'd7;
    stg_valid = 8'b0000_1001; stg_addr[4:0] = 5'd7; stg_addr[19:15] = 5'd7;
    stg_ready = 8'b0000_1000; stg_data[127:96] = 32'h3333;
    @(negedge clk);
    chk("t2_stall", 64'(stall), 64'd1);
    chk("t2_en1", 64'(byp_en[1]), 64'd0);
    chk("t2_cnt0", 64'(cnt), 64'd0);
    step(); @(negedge clk);
    chk("t2_cnt1", 64'(cnt), 64'd1);
    step(); @(negedge clk);
    chk("t2_cnt2", 64'(cnt), 64'd2);
    step();

    // Invisible producer: busy stall, then wb bypass releases it
    clr(); dec_valid = 1; wr_en = 1; wr_addr = 5'd9;
    @(negedge clk); chk("t3_issue", 64'(stall), 64'd0);
    step();
    clr(); dec_valid = 1; rd_use = 2'b01; rd_addr[4:0] = 5'd9;
    @(negedge clk); chk("t3_raw", 64'(stall), 64'd1);
    step();
    wb_en = 1; wb_addr = 5'd9; wb_data = 32'h1234;
    @(negedge clk);
    chk("t3_wb_stall", 64'(stall), 64'd0);
    chk("t3_wb_en", 64'(byp_en), 64'b01);
    chk("t3_wb_data", 64'(byp_data[31:0]), 64'h1234);
    step();
    wb_en = 0;
    @(negedge clk);
    chk("t3_cleared", 64'(stall), 64'd0);
    chk("t3_no_byp", 64'(byp_en), 64'd0);
    step();

    // WAW stall, resolved by same-cycle wb; new issue keeps r4 busy
    clr(); dec_valid = 1; wr_en = 1; wr_addr = 5'd4;
    @(negedge clk); chk("t4_first", 64'(stall), 64'd0);
    step(); @(negedge clk); chk("t4_waw", 64'(stall), 64'd1);
    step();
    wb_en = 1; wb_addr = 5'd4; wb_data = 32'h44;
    @(negedge clk); chk("t4_wb_nostall", 64'(stall), 64'd0);
    step();
    clr(); dec_valid = 1; rd_use = 2'b01; rd_addr[4:0] = 5'd4;
    @(negedge clk); chk("t4_still_busy", 64'(stall), 64'd1);
    step();

    // r0 never bypasses, stalls or becomes busy
    clr(); dec_valid = 1; rd_use = 2'b11; wr_en = 1; stg_valid = 8'hFF;
    wb_en = 1; wb_data = 32'h55;
    @(negedge clk);
    chk("t5_stall", 64'(stall), 64'd0);
    chk("t5_en", 64'(byp_en), 64'd0);
    chk("t5_data", byp_data, 64'd0);
    step();
    clr(); dec_valid = 1; wr_en = 1;
    @(negedge clk); chk("t5_no_waw", 64'(stall), 64'd0);
    step();

    // Flush clears busy the next cycle, not in the flush cycle
    clr(); dec_valid = 1; wr_en = 1; wr_addr = 5'd3;
    step(); wr_addr = 5'd6;
    step();
    clr(); dec_valid = 1; rd_use = 2'b11; rd_addr = {5'd6, 5'd3}; flush = 1;
    @(negedge clk); chk("t6_flush_cycle", 64'(stall), 64'd1);
    step(); flush = 0;
    @(negedge clk); chk("t6_after_flush", 64'(stall), 64'd0);
    step();

    // Counter saturation, then asynchronous reset mid-stall
    clr(); dec_valid = 1; rd_use = 2'b11; rd_addr = {5'd2, 5'd1};
    stg_valid = 8'b0000_0011; stg_addr[4:0] = 5'd1; stg_addr[9:5] = 5'd2;
    stg_ready = 8'b0000_0010; stg_data[63:32] = 32'hBEEF;
    repeat (20) step();
    @(negedge clk);
    chk("t6_sat", 64'(cnt), 64'hF);
    chk("t6_en_pre", 64'(byp_en), 64'b10);
    step(); @(negedge clk);
    chk("t6_hold", 64'(cnt), 64'hF);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("t6_async_stall", 64'(stall), 64'd0);
    chk("t6_async_en", 64'(byp_en), 64'd0);
    chk("t6_async_cnt", 64'(cnt), 64'd0);
    step(); step();
    rst = 1'b0;

    for (int i = 0; i < 1500; i++) begin
      rand_inputs();
      if (i == 700) rst = 1'b1;
      if (i == 702) rst = 1'b0;
      step();
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
